// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: accepts a byte, loads the serializer and drives START/DATA/PARITY/STOP.
// Optional parity support is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_ctrl #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_data,
  input  logic             ser_done,
  output logic             ser_en,
  output logic             TX_OUT,
  output logic             Busy,
  output logic             sync_err
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] bit_cnt_r;
  logic          done_seen_r;
  logic          sync_err_r;
  logic          accept_s;
  logic          watch_done_s;
  logic          tx_s;

`ifdef UART_TX_PARITY_EN
  logic par_en_r;
  logic par_bit_r;

  function automatic logic calc_parity(input logic [width-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`else
  logic unused_par_s;
  assign unused_par_s = PAR_EN ^ PAR_TYP;
`endif

  // Serializer load is combinational so it loads on the same edge we accept.
  assign accept_s = (state_r == IDLE) & DATA_VALID & ~RST;
  assign ser_en   = accept_s;
  assign Busy     = (state_r != IDLE);
  assign TX_OUT   = tx_s;
  assign sync_err = sync_err_r;

  // Line level and ser_done watch window decoded from the current state.
  always_comb begin
    tx_s         = 1'b1;
    watch_done_s = 1'b0;
    case (state_r)
      IDLE:   tx_s = 1'b1;
      START:  tx_s = 1'b0;
      DATA: begin
        tx_s         = ser_data;
        watch_done_s = (bit_cnt_r == LAST_BIT);
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_s         = par_bit_r;
        watch_done_s = 1'b1;
      end
`endif
      STOP: begin
        tx_s         = 1'b1;
        watch_done_s = 1'b1;
      end
      default: tx_s = 1'b1;
    endcase
  end

  // Frame sequencing, bit counter, latched frame options and lock-loss detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      bit_cnt_r   <= '0;
      done_seen_r <= 1'b0;
      sync_err_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_r    <= 1'b0;
      par_bit_r   <= 1'b0;
`endif
    end else begin
      sync_err_r <= 1'b0;
      if (watch_done_s && ser_done) begin
        done_seen_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (DATA_VALID) begin
            done_seen_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_r    <= PAR_EN;
            par_bit_r   <= calc_parity(P_DATA, PAR_TYP);
`endif
            state_r     <= START;
          end
        end
        START: begin
          bit_cnt_r <= '0;
          state_r   <= DATA;
        end
        DATA: begin
          bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_r <= par_en_r ? PARITY : STOP;
`else
            state_r <= STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state_r <= STOP;
`endif
        STOP: begin
          // ser_done on the exit edge itself still counts as seen.
          sync_err_r <= ~(done_seen_r | ser_done);
          state_r    <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected line bits, frame lengths and
// sync_err pulses; a negedge monitor pops and compares them against the DUT.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] P_DATA = 8'h00;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         ser_data;
  logic         ser_done;
  logic         ser_en;
  logic         TX_OUT;
  logic         Busy;
  logic         sync_err;

  int checks = 0;
  int errors = 0;

  logic exp_bits[$];
  int   exp_len[$];
  bit   exp_err[$];
  bit   prev_busy = 1'b0;
  int   busy_len = 0;

  // serializer model
  logic [W:0] ser_sh;
  int         ser_cnt;
  bit         ser_act;
  bit         done_en = 1'b1;

  uart_tx_ctrl #(.width(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data), .ser_done(ser_done),
    .ser_en(ser_en), .TX_OUT(TX_OUT), .Busy(Busy), .sync_err(sync_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) begin
      ser_sh  <= '0;
      ser_act <= 1'b0;
      ser_cnt <= 0;
    end else if (ser_en) begin
      ser_sh  <= {P_DATA, 1'b0};
      ser_act <= 1'b1;
      ser_cnt <= 0;
    end else if (ser_act) begin
      ser_sh  <= ser_sh >> 1;
      ser_cnt <= ser_cnt + 1;
      if (ser_cnt == W) ser_act <= 1'b0;
    end
  end
  assign ser_data = ser_sh[0];
  assign ser_done = done_en && ser_act && (ser_cnt == W);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d, input bit with_par, input logic par_bit);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_bits.push_back(d[i]);
    if (with_par) exp_bits.push_back(par_bit);
    exp_bits.push_back(1'b1);
    exp_len.push_back(with_par ? W + 3 : W + 2);
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    check("accept_ser_en", int'(ser_en), 1);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge CLK);
    while (Busy && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: Busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // monitor
  always @(negedge CLK) begin
    if (Busy === 1'b1) begin
      busy_len++;
      check("ser_en_while_busy", int'(ser_en), 0);
      if (exp_bits.size() == 0) begin
        check("tx_bit_unexpected", int'(TX_OUT), -1);
      end else begin
        check("tx_bit", int'(TX_OUT), int'(exp_bits.pop_front()));
      end
    end else if (prev_busy) begin
      if (exp_len.size() == 0) check("frame_len_unexpected", busy_len, -1);
      else check("frame_len", busy_len, exp_len.pop_front());
      busy_len = 0;
    end
    if (sync_err === 1'b1) begin
      if (exp_err.size() == 0) begin
        check("sync_err_unexpected", 1, 0);
      end else begin
        void'(exp_err.pop_front());
        check("sync_err_first_idle", int'(prev_busy && !Busy), 1);
      end
    end
    prev_busy = (Busy === 1'b1);
  end

  initial begin
    logic a5_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset then idle
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("idle_outputs", int'({TX_OUT, Busy, ser_en, sync_err}), 8);
    end

    // 0xA5 without parity, hand-computed line sequence
    foreach (a5_bits[i]) exp_bits.push_back(a5_bits[i]);
    exp_len.push_back(10);
    send(8'hA5, 1'b0, 1'b0);
    wait_idle(30);
    idle_cycles(2);

`ifdef UART_TX_PARITY_EN
    push_frame(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    wait_idle(30);
    idle_cycles(2);
    push_frame(8'hA5, 1'b1, 1'b1);
    send(8'hA5, 1'b1, 1'b1);
    wait_idle(30);
    idle_cycles(2);
`else
    push_frame(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b1);
    wait_idle(30);
    idle_cycles(2);
`endif

    // DATA_VALID held high across two frames
    push_frame(8'h01, 1'b0, 1'b0);
    push_frame(8'hFF, 1'b0, 1'b0);
    @(posedge CLK); #1;
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    P_DATA = 8'hFF;
    wait_idle(30);
    check("b2b_idle_accept", int'(ser_en), 1);
    @(posedge CLK); #1;
    check("b2b_busy_after_gap", int'(Busy), 1);
    DATA_VALID = 1'b0;
    wait_idle(30);
    idle_cycles(2);

    // reset in the 4th DATA cycle of 0x3C
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    exp_len.push_back(5);
    send(8'h3C, 1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_outputs", int'({TX_OUT, Busy, sync_err}), 4);
    idle_cycles(3);
    push_frame(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    wait_idle(30);
    idle_cycles(2);

    // ser_done missing
    done_en = 1'b0;
    push_frame(8'h55, 1'b0, 1'b0);
    exp_err.push_back(1'b1);
    send(8'h55, 1'b0, 1'b0);
    wait_idle(30);
    idle_cycles(4);
    done_en = 1'b1;

    check("bits_left", exp_bits.size(), 0);
    check("lens_left", exp_len.size(), 0);
    check("sync_err_left", exp_err.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
